// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary XNOR neuron: FSM state encoding,
// a floored clog2 for index widths, and a popcount over a wide vector.
package bnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Widest word the popcount helper can take; callers zero-extend into it.
   localparam int POP_MAX = 256;

   // Index width for a table of 'value' entries, never narrower than one bit.
   function automatic int clog2_min1(input int value);
      return (value < 2) ? 1 : $clog2(value);
   endfunction

   function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
      int unsigned cnt;
      cnt = 32'd0;
      for (int i = 0; i < POP_MAX; i++) begin
         cnt = cnt + {31'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational XNOR of one activation word against one weight word, followed
// by a popcount of the matching bits (+1 * +1 or -1 * -1 both count as a match).
module bnn_popcount
   import bnn_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
)(
   input  logic [WIDTH-1:0] i_act,
   input  logic [WIDTH-1:0] i_weight,
   output logic [CNT_W-1:0] o_count
);

   logic [POP_MAX-1:0] w_match;

   // Matching bits, zero-extended to the helper's fixed width.
   always_comb begin
      w_match              = {POP_MAX{1'b0}};
      w_match[WIDTH-1:0]   = ~(i_act ^ i_weight);
   end

   assign o_count = CNT_W'(popcount(w_match));

endmodule

// File: rtl/bnn_xnor_neuron.sv
// Multi-beat binary neuron: accumulates XNOR-popcounts of BEATS activation words
// against a programmable weight table, then thresholds the total into one bit.
module bnn_xnor_neuron
   import bnn_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int BEATS = 4,
   localparam int ACC_W = $clog2(WIDTH * BEATS + 1),
   localparam int AW    = clog2_min1(BEATS)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             w_wr,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic             th_wr,
   input  logic [ACC_W-1:0] th_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [ACC_W-1:0] out_sum,
   output logic             cfg_err
);

   localparam int            CNT_W     = $clog2(WIDTH + 1);
   localparam int            DEPTH     = 1 << AW;
   localparam logic [AW-1:0] LAST_BEAT = AW'(BEATS - 1);
   localparam logic [AW-1:0] BEAT_ONE  = AW'(1);
   localparam logic [AW:0]   BEATS_EXT = (AW + 1)'(BEATS);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_weight [DEPTH];
   logic [ACC_W-1:0]   r_th;
   logic [ACC_W-1:0]   r_acc;
   logic [AW-1:0]      r_beat;
   logic               r_in_ready;
   logic               r_out_bit;
   logic [ACC_W-1:0]   r_out_sum;
   logic               r_cfg_err;

   logic               w_accept;
   logic               w_last;
   logic               w_cfg_open;
   logic               w_addr_bad;
   logic [WIDTH-1:0]   w_weight_sel;
   logic [CNT_W-1:0]   w_pop;
   logic [ACC_W-1:0]   w_base;
   logic [ACC_W-1:0]   w_sum;

   assign w_accept     = in_valid && r_in_ready;
   assign w_last       = (r_beat == LAST_BEAT);
   assign w_cfg_open   = (r_state != ST_ACCUM);
   assign w_addr_bad   = ({1'b0, w_addr} >= BEATS_EXT);
   assign w_weight_sel = r_weight[r_beat];
   // Beat 0 starts a fresh sum so nothing from the previous inference leaks in.
   assign w_base       = (r_beat == {AW{1'b0}}) ? {ACC_W{1'b0}} : r_acc;
   assign w_sum        = w_base + ACC_W'(w_pop);

   bnn_popcount #(.WIDTH(WIDTH)) u_popcount (
      .i_act    (in_data),
      .i_weight (w_weight_sel),
      .o_count  (w_pop)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; IDLE and ACCUM share the beat-acceptance rule.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_ACCUM: begin
            if (w_accept && w_last) begin
               w_state_nxt = ST_DONE;
            end else if (w_accept) begin
               w_state_nxt = ST_ACCUM;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Beat counter, accumulator and registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_beat     <= {AW{1'b0}};
         r_acc      <= {ACC_W{1'b0}};
         r_in_ready <= 1'b0;
         r_out_bit  <= 1'b0;
         r_out_sum  <= {ACC_W{1'b0}};
      end else begin
         r_in_ready <= (w_state_nxt != ST_DONE);
         if (w_accept) begin
            r_beat <= w_last ? {AW{1'b0}} : (r_beat + BEAT_ONE);
            r_acc  <= w_sum;
         end
         // Threshold is sampled here, on the edge that enters DONE.
         if (w_accept && w_last) begin
            r_out_sum <= w_sum;
            r_out_bit <= (w_sum >= r_th);
         end
      end
   end

   // Weight table and threshold; writes only land outside ACCUM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_weight[i] <= {WIDTH{1'b0}};
         end
         r_th      <= {ACC_W{1'b0}};
         r_cfg_err <= 1'b0;
      end else begin
         if (w_wr && w_cfg_open && !w_addr_bad) begin
            r_weight[w_addr] <= w_data;
         end
         if (th_wr && w_cfg_open) begin
            r_th <= th_data;
         end
         r_cfg_err <= (w_wr && (!w_cfg_open || w_addr_bad)) || (th_wr && !w_cfg_open);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == ST_DONE);
   assign out_bit   = r_out_bit;
   assign out_sum   = r_out_sum;
   assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_bnn_xnor_neuron.sv
// Self-checking bench for bnn_xnor_neuron: randomized inferences compared with a
// bit-match counting model, plus a 3-beat instance for out-of-range weight addresses.
module tb_bnn_xnor_neuron;

   localparam int WIDTH = 8;
   localparam int BEATS = 4;
   localparam int ACC_W = 6;
   localparam int AW    = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic             rst, w_wr, th_wr, in_valid, out_ready;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_data, in_data;
   logic [ACC_W-1:0] th_data;
   logic             in_ready, out_valid, out_bit, cfg_err;
   logic [ACC_W-1:0] out_sum;

   logic       d3_w_wr, d3_th_wr, d3_in_valid, d3_out_ready;
   logic [1:0] d3_w_addr;
   logic [3:0] d3_w_data, d3_in_data, d3_th_data;
   logic       d3_in_ready, d3_out_valid, d3_out_bit, d3_cfg_err;
   logic [3:0] d3_out_sum;

   bnn_xnor_neuron #(.WIDTH(WIDTH), .BEATS(BEATS)) u_dut (
      .clk(clk), .rst(rst), .w_wr(w_wr), .w_addr(w_addr), .w_data(w_data),
      .th_wr(th_wr), .th_data(th_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_bit(out_bit), .out_sum(out_sum), .cfg_err(cfg_err)
   );

   bnn_xnor_neuron #(.WIDTH(4), .BEATS(3)) u_dut3 (
      .clk(clk), .rst(rst), .w_wr(d3_w_wr), .w_addr(d3_w_addr), .w_data(d3_w_data),
      .th_wr(d3_th_wr), .th_data(d3_th_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .in_data(d3_in_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
      .out_bit(d3_out_bit), .out_sum(d3_out_sum), .cfg_err(d3_cfg_err)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] m_w [4];
   logic [5:0] m_th;

   // Count positions where activation and weight agree (+1*+1 or -1*-1).
   function automatic int model_sum(input logic [7:0] wt [4], input logic [7:0] act [4]);
      int s = 0;
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 8; k++)
            if (wt[b][k] == act[b][k]) s++;
      return s;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_weight(input int addr, input logic [7:0] data);
      w_wr = 1'b1; w_addr = AW'(addr); w_data = data;
      tick;
      w_wr = 1'b0;
      m_w[addr] = data;
   endtask

   task automatic write_th(input logic [5:0] v);
      th_wr = 1'b1; th_data = v;
      tick;
      th_wr = 1'b0;
      m_th = v;
   endtask

   task automatic release_out;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
   endtask

   // Feed beats first..3 with random idle gaps; lat = cycles from last accept to out_valid.
   task automatic drive_beats(input logic [7:0] act [4], input int first, input int gap_pct,
                              output int lat, output int t_valid);
      int   i = first;
      int   guard = 0;
      logic rdy;
      while (i < 4 && guard < 500) begin
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = in_valid ? act[i] : 8'($urandom);
         rdy      = in_ready;
         tick;
         guard++;
         if (in_valid && rdy) i++;
      end
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick;
         lat++;
      end
      t_valid = cyc;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit got %b want 0", out_bit); end
      checks++; if (out_sum !== 6'd0) begin errors++; $display("FAIL reset_out_sum got %0d want 0", out_sum); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_w[i] = 8'h00;
      m_th = 6'd0;
      tick;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_basic;
      logic [7:0] act [4];
      int lat, t, exp;
      for (int a = 0; a < 4; a++) write_weight(a, 8'hFF);
      write_th(6'd16);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL legal_write_cfg_err got %b want 0", cfg_err); end
      act[0] = 8'hFF; act[1] = 8'hFF; act[2] = 8'h00; act[3] = 8'h00;
      drive_beats(act, 0, 0, lat, t);
      exp = model_sum(m_w, act);
      checks++; if (lat !== 0) begin errors++; $display("FAIL basic_latency got %0d want 0", lat); end
      checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL basic_sum got %0d want %0d", out_sum, exp); end
      checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL basic_bit got %b want 1", out_bit); end
      release_out;
   endtask

   task automatic test_threshold;
      logic [7:0] act [4];
      logic [5:0] ths [3];
      int lat, t, exp;
      ths[0] = 6'd17; ths[1] = 6'd0; ths[2] = 6'd33;
      for (int b = 0; b < 4; b++) act[b] = 8'h0F;
      for (int k = 0; k < 3; k++) begin
         write_th(ths[k]);
         drive_beats(act, 0, 20, lat, t);
         exp = model_sum(m_w, act);
         checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL th_sum got %0d want %0d", out_sum, exp); end
         checks++; if (out_bit !== (exp >= int'(m_th))) begin errors++; $display("FAIL th_bit th=%0d got %b want %b", m_th, out_bit, exp >= int'(m_th)); end
         release_out;
      end
   endtask

   task automatic test_stall;
      logic [7:0] act [4];
      int lat, t, exp;
      logic ebit;
      act[0] = 8'hA5; act[1] = 8'h5A; act[2] = 8'h00; act[3] = 8'hFF;
      for (int a = 0; a < 4; a++) write_weight(a, act[a]);
      write_th(6'($urandom_range(33)));
      drive_beats(act, 0, 40, lat, t);
      exp  = model_sum(m_w, act);
      ebit = (exp >= int'(m_th));
      checks++; if (lat !== 0) begin errors++; $display("FAIL stall_latency got %0d want 0", lat); end
      for (int c = 0; c < 5; c++) begin
         checks++; if (out_valid !== 1'b1 || out_sum !== 6'(exp) || out_bit !== ebit || in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_hold cyc%0d got v=%b s=%0d b=%b rdy=%b want v=1 s=%0d b=%b rdy=0",
                               c, out_valid, out_sum, out_bit, in_ready, exp, ebit);
         end
         tick;
      end
      release_out;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
   endtask

   task automatic test_cfg_err;
      logic [7:0] act [4];
      int lat, t, exp;
      for (int a = 0; a < 4; a++) write_weight(a, 8'($urandom));
      write_th(6'($urandom_range(32)));
      for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
      in_valid = 1'b1; in_data = act[0]; tick;
      in_data = act[1]; tick;
      in_valid = 1'b0;
      w_wr = 1'b1; w_addr = 2'd2; w_data = ~m_w[2];
      th_wr = 1'b1; th_data = ~m_th;
      tick;
      w_wr = 1'b0; th_wr = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL accum_cfg_err got %b want 1", cfg_err); end
      tick;
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got %b want 0", cfg_err); end
      drive_beats(act, 2, 30, lat, t);
      exp = model_sum(m_w, act);
      checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL dropped_write_sum got %0d want %0d", out_sum, exp); end
      checks++; if (out_bit !== (exp >= int'(m_th))) begin errors++; $display("FAIL dropped_write_bit got %b want %b", out_bit, exp >= int'(m_th)); end
      release_out;
   endtask

   task automatic test_same_cycle_write;
      logic [7:0] act [4];
      logic [7:0] nw;
      int lat, t, exp;
      for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
      nw = ~m_w[0];
      in_valid = 1'b1; in_data = act[0];
      w_wr = 1'b1; w_addr = 2'd0; w_data = nw;
      tick;
      w_wr = 1'b0; in_valid = 1'b0;
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL idle_write_cfg_err got %b want 0", cfg_err); end
      drive_beats(act, 1, 0, lat, t);
      exp = model_sum(m_w, act);
      checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL old_weight_sum got %0d want %0d", out_sum, exp); end
      release_out;
      m_w[0] = nw;
      drive_beats(act, 0, 0, lat, t);
      exp = model_sum(m_w, act);
      checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL new_weight_sum got %0d want %0d", out_sum, exp); end
      release_out;
   endtask

   task automatic test_back_to_back;
      logic [7:0] act [4];
      int lat, t, t_prev, exp;
      for (int a = 0; a < 4; a++) write_weight(a, 8'($urandom));
      write_th(6'($urandom_range(32)));
      out_ready = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
         drive_beats(act, 0, 0, lat, t);
         exp = model_sum(m_w, act);
         checks++; if (out_sum !== 6'(exp) || out_bit !== (exp >= int'(m_th))) begin
            errors++; $display("FAIL b2b_result got s=%0d b=%b want s=%0d b=%b", out_sum, out_bit, exp, exp >= int'(m_th));
         end
         if (k > 0) begin
            checks++; if (t - t_prev !== BEATS + 1) begin errors++; $display("FAIL b2b_period got %0d want %0d", t - t_prev, BEATS + 1); end
         end
         t_prev = t;
      end
      tick;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [7:0] act [4];
      int lat, t, exp;
      for (int a = 0; a < 4; a++) write_weight(a, 8'($urandom));
      write_th(6'd40);
      for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
      in_valid = 1'b1; in_data = act[0]; tick;
      in_data = act[1]; tick;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_sum !== 6'd0 || out_bit !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset got v=%b s=%0d b=%b rdy=%b want all 0", out_valid, out_sum, out_bit, in_ready);
      end
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_w[i] = 8'h00;
      m_th = 6'd0;
      tick;
      for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
      drive_beats(act, 0, 20, lat, t);
      exp = model_sum(m_w, act);
      checks++; if (out_sum !== 6'(exp)) begin errors++; $display("FAIL post_reset_sum got %0d want %0d", out_sum, exp); end
      checks++; if (out_bit !== 1'b1) begin errors++; $display("FAIL post_reset_bit got %b want 1", out_bit); end
      release_out;
   endtask

   task automatic test_random;
      logic [7:0] act [4];
      int lat, t, exp;
      for (int it = 0; it < 20; it++) begin
         repeat ($urandom_range(3)) write_weight($urandom_range(3), 8'($urandom));
         if ($urandom_range(1) == 1) write_th(6'($urandom_range(34)));
         for (int b = 0; b < 4; b++) act[b] = 8'($urandom);
         drive_beats(act, 0, 30, lat, t);
         exp = model_sum(m_w, act);
         checks++; if (lat !== 0 || out_sum !== 6'(exp) || out_bit !== (exp >= int'(m_th))) begin
            errors++; $display("FAIL random_%0d got lat=%0d s=%0d b=%b want lat=0 s=%0d b=%b",
                               it, lat, out_sum, out_bit, exp, exp >= int'(m_th));
         end
         repeat ($urandom_range(3)) tick;
         release_out;
      end
   endtask

   task automatic test_addr_range;
      logic [3:0] w3 [3];
      logic [3:0] a3 [3];
      int exp = 0;
      for (int a = 0; a < 3; a++) begin
         w3[a] = 4'($urandom);
         d3_w_wr = 1'b1; d3_w_addr = 2'(a); d3_w_data = w3[a];
         tick;
      end
      d3_w_addr = 2'd3; d3_w_data = 4'($urandom);
      tick;
      d3_w_wr = 1'b0;
      checks++; if (d3_cfg_err !== 1'b1) begin errors++; $display("FAIL addr_range_cfg_err got %b want 1", d3_cfg_err); end
      for (int b = 0; b < 3; b++) begin
         a3[b] = 4'($urandom);
         for (int k = 0; k < 4; k++) if (a3[b][k] == w3[b][k]) exp++;
      end
      for (int b = 0; b < 3; b++) begin
         d3_in_valid = 1'b1; d3_in_data = a3[b];
         tick;
      end
      d3_in_valid = 1'b0;
      checks++; if (d3_out_valid !== 1'b1 || d3_out_sum !== 4'(exp) || d3_out_bit !== 1'b1) begin
         errors++; $display("FAIL addr_range_sum got v=%b s=%0d b=%b want v=1 s=%0d b=1", d3_out_valid, d3_out_sum, d3_out_bit, exp);
      end
      d3_out_ready = 1'b1;
      tick;
      d3_out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; w_wr = 1'b0; th_wr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      w_addr = 2'd0; w_data = 8'h00; th_data = 6'd0; in_data = 8'h00;
      d3_w_wr = 1'b0; d3_th_wr = 1'b0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
      d3_w_addr = 2'd0; d3_w_data = 4'h0; d3_th_data = 4'h0; d3_in_data = 4'h0;
      test_reset;
      test_basic;
      test_threshold;
      test_stall;
      test_cfg_err;
      test_same_cycle_write;
      test_back_to_back;
      test_reset_mid;
      test_random;
      test_addr_range;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
